// File: rtl/red_pitaya_cordic_pkg.sv
// rtl/red_pitaya_cordic_pkg.sv - shared CORDIC constants for the rotator and PFD blocks
package red_pitaya_cordic_pkg;

  // 1/1.16443 as a Q15 multiplier; it undoes the gain of iterations with shifts 1..N
  localparam int CORDIC_GAIN_COMP  = 28141;
  localparam int CORDIC_GAIN_SHIFT = 15;

  // atan(2^-(n+1)) in units of 2^15 per full turn, rounded to nearest
  localparam int CORDIC_ATAN_DEPTH = 16;
  localparam int CORDIC_ATAN [CORDIC_ATAN_DEPTH] = '{
    2418, 1278, 649, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0, 0, 0
  };

  // Coarse quadrant selected before the fine iterations
  typedef enum logic [1:0] {
    QUAD_0   = 2'd0,
    QUAD_90  = 2'd1,
    QUAD_180 = 2'd2,
    QUAD_270 = 2'd3
  } cordic_quad_e;

endpackage

// File: rtl/red_pitaya_cordic_rot_stage.sv
// rtl/red_pitaya_cordic_rot_stage.sv - one registered CORDIC micro-rotation
module red_pitaya_cordic_rot_stage #(
  parameter int WIDTH  = 20,
  parameter int ZWIDTH = 15,
  parameter int SHIFT  = 1,
  parameter int ANGLE  = 2418
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [WIDTH-1:0]  i_x,
  input  logic signed [WIDTH-1:0]  i_y,
  input  logic signed [ZWIDTH-1:0] i_z,
  output logic signed [WIDTH-1:0]  o_x,
  output logic signed [WIDTH-1:0]  o_y,
  output logic signed [ZWIDTH-1:0] o_z
);

  localparam logic signed [ZWIDTH-1:0] ANG = ZWIDTH'(ANGLE);

  logic signed [WIDTH-1:0]  w_xs;
  logic signed [WIDTH-1:0]  w_ys;
  logic signed [WIDTH-1:0]  r_x;
  logic signed [WIDTH-1:0]  r_y;
  logic signed [ZWIDTH-1:0] r_z;

  assign w_xs = i_x >>> SHIFT;
  assign w_ys = i_y >>> SHIFT;

  // Rotate towards z = 0: counter-clockwise while residual is non-negative
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
    end else if (!i_z[ZWIDTH-1]) begin
      r_x <= i_x - w_ys;
      r_y <= i_y + w_xs;
      r_z <= i_z - ANG;
    end else begin
      r_x <= i_x + w_ys;
      r_y <= i_y - w_xs;
      r_z <= i_z + ANG;
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;
  assign o_z = r_z;

endmodule

// File: rtl/red_pitaya_cordic_rot_block.sv
// rtl/red_pitaya_cordic_rot_block.sv - pipelined CORDIC rotator producing amp*cos/sin of a phase
module red_pitaya_cordic_rot_block
  import red_pitaya_cordic_pkg::*;
#(
  parameter int SIGNALBITS   = 14,
  parameter int WORKINGWIDTH = 20,
  parameter int PHASEWIDTH   = 15,
  parameter int NSTAGES      = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic signed [SIGNALBITS-1:0] amp_i,
  input  logic        [PHASEWIDTH-1:0] phase_i,
  input  logic        [PHASEWIDTH-1:0] phase_inc_i,
  input  logic                         acc_en_i,
  input  logic                         sync_i,
  output logic signed [SIGNALBITS-1:0] i_o,
  output logic signed [SIGNALBITS-1:0] q_o,
  output logic                         valid_o
);

  localparam int SB    = SIGNALBITS;
  localparam int WW    = WORKINGWIDTH;
  localparam int PW    = PHASEWIDTH;
  localparam int DROP  = WW - SB - 2;
  localparam int PRODW = SB + 16;
  localparam int LAT   = NSTAGES + 3;

  localparam logic signed [PRODW-1:0] GAIN = PRODW'(CORDIC_GAIN_COMP);
  localparam logic signed [WW:0]      HALF = (WW+1)'((1 << DROP) >> 1);
  localparam logic signed [WW:0]      MAXV = (WW+1)'((1 << (SB-1)) - 1);
  localparam logic signed [WW:0]      MINV = (WW+1)'(-(1 << (SB-1)));

  // Phase accumulator and per-sample phase selection
  logic [PW-1:0] r_acc;
  logic [PW-1:0] w_phase_sel;

  assign w_phase_sel = acc_en_i ? r_acc : phase_i;

  // Sync wins over the increment; the current sample still sees the old value
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc <= '0;
    end else if (sync_i) begin
      r_acc <= '0;
    end else if (valid_i && acc_en_i) begin
      r_acc <= r_acc + phase_inc_i;
    end
  end

  // Stage 0: gain compensation, placed with 2 headroom bits and DROP guard bits
  logic signed [PRODW-1:0] w_prod;
  logic signed [PRODW-1:0] w_shift;
  logic signed [SB-1:0]    w_scaled;
  logic signed [WW-1:0]    w_amp_work;
  logic signed [WW-1:0]    r_amp;
  logic        [PW-1:0]    r_phase;

  assign w_prod     = PRODW'(amp_i) * GAIN;
  assign w_shift    = w_prod >>> CORDIC_GAIN_SHIFT;
  assign w_scaled   = w_shift[SB-1:0];
  assign w_amp_work = WW'(w_scaled) <<< DROP;

  // Register scaled amplitude and chosen phase
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_amp   <= '0;
      r_phase <= '0;
    end else begin
      r_amp   <= w_amp_work;
      r_phase <= w_phase_sel;
    end
  end

  // Stage 1: coarse 90-degree pre-rotation leaves a residual within +/-45 degrees
  logic [PW-1:0]        w_ph_off;
  cordic_quad_e         w_quad;
  logic signed [PW-1:0] w_zres;
  logic signed [WW-1:0] w_x0;
  logic signed [WW-1:0] w_y0;
  logic signed [WW-1:0] r_x1;
  logic signed [WW-1:0] r_y1;
  logic signed [PW-1:0] r_z1;

  assign w_ph_off = r_phase + PW'(1 << (PW-3));
  assign w_quad   = cordic_quad_e'(w_ph_off[PW-1 -: 2]);
  assign w_zres   = $signed(r_phase - {w_quad, {(PW-2){1'b0}}});

  // Starting vector for each quadrant
  always_comb begin
    w_x0 = r_amp;
    w_y0 = '0;
    case (w_quad)
      QUAD_90:  begin w_x0 = '0;     w_y0 = r_amp;  end
      QUAD_180: begin w_x0 = -r_amp; w_y0 = '0;     end
      QUAD_270: begin w_x0 = '0;     w_y0 = -r_amp; end
      default:  ;
    endcase
  end

  // Register the pre-rotated vector and residual angle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x1 <= '0;
      r_y1 <= '0;
      r_z1 <= '0;
    end else begin
      r_x1 <= w_x0;
      r_y1 <= w_y0;
      r_z1 <= w_zres;
    end
  end

  // Fine iterations with shifts 1..NSTAGES
  logic signed [WW-1:0] w_x [0:NSTAGES];
  logic signed [WW-1:0] w_y [0:NSTAGES];
  logic signed [PW-1:0] w_z [0:NSTAGES];

  assign w_x[0] = r_x1;
  assign w_y[0] = r_y1;
  assign w_z[0] = r_z1;

  for (genvar n = 0; n < NSTAGES; n++) begin : g_stage
    red_pitaya_cordic_rot_stage #(
      .WIDTH  (WW),
      .ZWIDTH (PW),
      .SHIFT  (n + 1),
      .ANGLE  (CORDIC_ATAN[n])
    ) u_stage (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_x   (w_x[n]),
      .i_y   (w_y[n]),
      .i_z   (w_z[n]),
      .o_x   (w_x[n+1]),
      .o_y   (w_y[n+1]),
      .o_z   (w_z[n+1])
    );
  end

  // Output: round half-up while dropping guard bits, then clamp to SB bits
  function automatic logic signed [SB-1:0] sat(input logic signed [WW:0] v);
    if (v > MAXV) return MAXV[SB-1:0];
    if (v < MINV) return MINV[SB-1:0];
    return v[SB-1:0];
  endfunction

  logic signed [WW:0]   w_xr;
  logic signed [WW:0]   w_yr;
  logic signed [SB-1:0] r_i;
  logic signed [SB-1:0] r_q;

  assign w_xr = ((WW+1)'(w_x[NSTAGES]) + HALF) >>> DROP;
  assign w_yr = ((WW+1)'(w_y[NSTAGES]) + HALF) >>> DROP;

  // Register the final saturated I/Q
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_i <= '0;
      r_q <= '0;
    end else begin
      r_i <= sat(w_xr);
      r_q <= sat(w_yr);
    end
  end

  // Valid strobe travels alongside the data
  logic [LAT-1:0] r_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else begin
      r_valid <= {r_valid[LAT-2:0], valid_i};
    end
  end

  assign i_o     = r_i;
  assign q_o     = r_q;
  assign valid_o = r_valid[LAT-1];

  // Bits that are intentionally discarded
  logic w_unused;
  assign w_unused = &{1'b0, w_shift[PRODW-1:SB], w_ph_off[PW-3:0], w_z[NSTAGES]};

endmodule

// File: tb/tb_red_pitaya_cordic_rot_block.sv
// tb/tb_red_pitaya_cordic_rot_block.sv - directed self-checking bench for the CORDIC rotator
module tb_red_pitaya_cordic_rot_block;

  localparam int LAT = 15;

  logic clk = 1'b0;
  logic rst;
  logic valid_i;
  logic acc_en_i;
  logic sync_i;
  logic signed [13:0] amp_i;
  logic [14:0] phase_i;
  logic [14:0] phase_inc_i;
  logic signed [13:0] i_o;
  logic signed [13:0] q_o;
  logic valid_o;

  always #5 clk = ~clk;

  red_pitaya_cordic_rot_block dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (valid_i),
    .amp_i       (amp_i),
    .phase_i     (phase_i),
    .phase_inc_i (phase_inc_i),
    .acc_en_i    (acc_en_i),
    .sync_i      (sync_i),
    .i_o         (i_o),
    .q_o         (q_o),
    .valid_o     (valid_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    n_chk++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  typedef struct {
    logic v;
    logic en;
    logic sy;
    int   amp;
    int   ph;
    int   inc;
  } drv_t;

  typedef struct {
    string name;
    int    amp;
    int    ph;
    int    ei;
    int    eq;
    int    tol_i;
    int    tol_q;
  } vec_t;

  drv_t seq[$];
  int   out_i[$];
  int   out_q[$];
  int   out_lat[$];

  task automatic push(input logic v, input logic en, input logic sy,
                      input int amp, input int ph, input int inc);
    drv_t d;
    d.v = v; d.en = en; d.sy = sy; d.amp = amp; d.ph = ph; d.inc = inc;
    seq.push_back(d);
  endtask

  // Drive seq on consecutive negedges, then idle; collect every valid output
  task automatic run_seq();
    int in_idx[$];
    out_i.delete();
    out_q.delete();
    out_lat.delete();
    for (int c = 0; c < seq.size() + LAT + 25; c++) begin
      if (c < seq.size()) begin
        valid_i     = seq[c].v;
        acc_en_i    = seq[c].en;
        sync_i      = seq[c].sy;
        amp_i       = 14'(seq[c].amp);
        phase_i     = 15'(seq[c].ph);
        phase_inc_i = 15'(seq[c].inc);
        if (seq[c].v) in_idx.push_back(c);
      end else begin
        valid_i = 1'b0;
        sync_i  = 1'b0;
      end
      @(negedge clk);
      if (valid_o) begin
        out_i.push_back(int'(i_o));
        out_q.push_back(int'(q_o));
        if (in_idx.size() > 0) out_lat.push_back(c + 1 - in_idx.pop_front());
        else out_lat.push_back(-1);
      end
    end
    seq.delete();
  endtask

  vec_t vecs[8];
  int   hs_i[5];
  int   hs_q[5];
  int   stale;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"dir_ph0000",  8191, 'h0000,  8191,     0, 3, 3};
    vecs[1] = '{"dir_ph2000",  8191, 'h2000,     0,  8191, 3, 3};
    vecs[2] = '{"dir_ph1000",  8191, 'h1000,  5792,  5792, 3, 3};
    vecs[3] = '{"dir_ph7000",  8191, 'h7000,  5792, -5792, 3, 3};
    vecs[4] = '{"sat_ph4000", -8192, 'h4000,  8191,     0, 0, 3};
    vecs[5] = '{"dir_ph4000",  8191, 'h4000, -8191,     0, 3, 3};
    vecs[6] = '{"small_amp",    100, 'h1000,    71,    71, 3, 3};
    vecs[7] = '{"neg_amp",    -4000, 'h0000, -4000,     0, 3, 3};

    hs_i = '{8191,    0, 5792, -8191, 8191};
    hs_q = '{   0, 8191, 5792,     0,    0};

    rst = 1'b1; valid_i = 1'b0; acc_en_i = 1'b0; sync_i = 1'b0;
    amp_i = '0; phase_i = '0; phase_inc_i = '0;
    repeat (3) @(negedge clk);
    check_tol("reset_valid_o", int'(valid_o), 0, 0);
    check_tol("reset_i_o", int'(i_o), 0, 0);
    check_tol("reset_q_o", int'(q_o), 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Direct-phase table
    for (int k = 0; k < 8; k++) begin
      push(1'b1, 1'b0, 1'b0, vecs[k].amp, vecs[k].ph, 0);
      run_seq();
      check_tol({vecs[k].name, "_count"}, out_i.size(), 1, 0);
      if (out_i.size() >= 1) begin
        check_tol({vecs[k].name, "_latency"}, out_lat[0], LAT, 0);
        check_tol({vecs[k].name, "_i"}, out_i[0], vecs[k].ei, vecs[k].tol_i);
        check_tol({vecs[k].name, "_q"}, out_q[0], vecs[k].eq, vecs[k].tol_q);
      end
    end

    // Accumulator: sync then 32 samples stepping 22.5 degrees
    push(1'b0, 1'b1, 1'b1, 8191, 0, 'h0800);
    for (int k = 0; k < 32; k++) push(1'b1, 1'b1, 1'b0, 8191, 'h1234, 'h0800);
    run_seq();
    check_tol("acc_count", out_i.size(), 32, 0);
    if (out_i.size() == 32) begin
      check_tol("acc_latency", out_lat[0], LAT, 0);
      check_tol("acc_s0_i", out_i[0], 8191, 3);
      check_tol("acc_s0_q", out_q[0], 0, 3);
      check_tol("acc_s4_i", out_i[4], 0, 3);
      check_tol("acc_s4_q", out_q[4], 8191, 3);
      check_tol("acc_s8_i", out_i[8], -8191, 3);
      check_tol("acc_s12_q", out_q[12], -8191, 3);
      for (int k = 0; k < 16; k++) begin
        check_tol($sformatf("acc_period_i_%0d", k), out_i[k + 16], out_i[k], 0);
        check_tol($sformatf("acc_period_q_%0d", k), out_q[k + 16], out_q[k], 0);
      end
    end

    // Hold with acc_en=0, and sync in the same cycle as a sample
    push(1'b0, 1'b1, 1'b1, 8191, 0,      'h2000);
    push(1'b1, 1'b1, 1'b0, 8191, 'h6000, 'h2000);
    push(1'b1, 1'b1, 1'b0, 8191, 'h6000, 'h2000);
    push(1'b1, 1'b0, 1'b0, 8191, 'h1000, 'h2000);
    push(1'b1, 1'b1, 1'b1, 8191, 'h6000, 'h2000);
    push(1'b1, 1'b1, 1'b0, 8191, 'h6000, 'h2000);
    run_seq();
    check_tol("hs_count", out_i.size(), 5, 0);
    if (out_i.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        check_tol($sformatf("hs_i_%0d", k), out_i[k], hs_i[k], 3);
        check_tol($sformatf("hs_q_%0d", k), out_q[k], hs_q[k], 3);
      end
    end

    // Reset mid-stream: fill pipeline, start a burst, reset 7 cycles in
    acc_en_i = 1'b0; sync_i = 1'b0; amp_i = 14'sd8191; phase_i = 15'h1000;
    valid_i = 1'b0;
    repeat (20) @(negedge clk);
    valid_i = 1'b1;
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    valid_i = 1'b0;
    #1;
    check_tol("midrst_valid_o", int'(valid_o), 0, 0);
    check_tol("midrst_i_o", int'(i_o), 0, 0);
    check_tol("midrst_q_o", int'(q_o), 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (valid_o) stale++;
    end
    check_tol("midrst_stale_outputs", stale, 0, 0);

    // First sample after reset uses the cleared accumulator
    push(1'b1, 1'b1, 1'b0, 8191, 'h3000, 'h0400);
    run_seq();
    check_tol("postrst_count", out_i.size(), 1, 0);
    if (out_i.size() >= 1) begin
      check_tol("postrst_latency", out_lat[0], LAT, 0);
      check_tol("postrst_i", out_i[0], 8191, 3);
      check_tol("postrst_q", out_q[0], 0, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
